// File: rtl/dla_xbar_pkg.sv
// ---------------------------------------------------------------------------
// dla_xbar_pkg
// Shared types and default sizing for the xbar config collector slice.
//   xbar_cfg_state_e          : collector FSM states (COLLECT, HOLD)
//   DEFAULT_CONFIG_DATA_WIDTH : width of one config beat
//   DEFAULT_CONFIG_BEAT_COUNT : beats per xbar config packet
// ---------------------------------------------------------------------------
package dla_xbar_pkg;

  localparam int DEFAULT_CONFIG_DATA_WIDTH = 32;
  localparam int DEFAULT_CONFIG_BEAT_COUNT = 4;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } xbar_cfg_state_e;

endpackage

// File: rtl/dla_xbar_config_collector_if.sv
// ---------------------------------------------------------------------------
// dla_xbar_config_collector_if
// Config beat stream (valid/ready handshake).
//   config_data  : beat payload, DW bits
//   config_valid : beat valid (source -> sink)
//   config_ready : beat accepted when valid & ready (sink -> source)
// Modports: master = beat source, slave = beat sink.
// ---------------------------------------------------------------------------
interface dla_xbar_config_collector_if
  import dla_xbar_pkg::*;
#(
  parameter int DW = DEFAULT_CONFIG_DATA_WIDTH
) ();

  logic [DW-1:0] config_data;
  logic          config_valid;
  logic          config_ready;

  modport master (output config_data, output config_valid, input  config_ready);
  modport slave  (input  config_data, input  config_valid, output config_ready);

endinterface

// File: rtl/dla_xbar_config_beat_assembler.sv
// ---------------------------------------------------------------------------
// dla_xbar_config_beat_assembler
// Beat counter plus packet register. Beat k lands in pkt_o[k*DW +: DW]; the
// counter wraps to 0 on the last beat, with done_o flagging that handshake.
//   clk, i_aresetn : clock, asynchronous active-low reset
//   en_i           : collector allows this buffer to take beats
//   beat_if        : beat stream sink (ready mirrors en_i)
//   pkt_o          : assembled packet, DW*BC bits
//   count_o        : beats accepted into the packet in progress
//   done_o         : last beat of a packet accepted this cycle
// ---------------------------------------------------------------------------
module dla_xbar_config_beat_assembler
  import dla_xbar_pkg::*;
#(
  parameter int DW = DEFAULT_CONFIG_DATA_WIDTH,
  parameter int BC = DEFAULT_CONFIG_BEAT_COUNT,
  parameter int CW = $clog2(BC) + 1
) (
  input  logic                  clk,
  input  logic                  i_aresetn,
  input  logic                  en_i,
  dla_xbar_config_collector_if.slave beat_if,
  output logic [DW*BC-1:0]      pkt_o,
  output logic [CW-1:0]         count_o,
  output logic                  done_o
);

  logic [CW-1:0] count_q;
  logic          accept;

  assign beat_if.config_ready = en_i;
  assign accept  = beat_if.config_valid & en_i;
  assign done_o  = accept & (count_q == CW'(BC - 1));
  assign count_o = count_q;

  always_ff @(posedge clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= done_o ? '0 : count_q + 1'b1;
    end
  end

  // One register per beat slot; the counter selects which slot captures.
  for (genvar gi = 0; gi < BC; gi++) begin : g_word
    logic [DW-1:0] word_q;

    always_ff @(posedge clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
        word_q <= '0;
      end else if (accept && (count_q == CW'(gi))) begin
        word_q <= beat_if.config_data;
      end
    end

    assign pkt_o[gi*DW +: DW] = word_q;
  end

endmodule

// File: rtl/dla_xbar_config_collector.sv
// ---------------------------------------------------------------------------
// dla_xbar_config_collector
// Collects CONFIG_BEAT_COUNT config beats into one packet for the xbar
// control FSM and holds it until serviced.
//   clk                 : clock (rising edge)
//   i_aresetn           : asynchronous active-low reset
//   i_config_data/valid : beat input, o_config_ready : beat accepted
//   o_config_pkt        : assembled packet (beat 0 in LSBs)
//   o_config_pkt_valid  : packet complete and held
//   i_config_serviced   : consumer has copied the packet
//   o_config_beat_count : beats accepted into the packet in progress
// Optional macro DLA_XBAR_CONFIG_PREFETCH_EN adds a shadow buffer so beats
// keep flowing while a packet is held (back-to-back packets).
// ---------------------------------------------------------------------------
module dla_xbar_config_collector
  import dla_xbar_pkg::*;
#(
  parameter int CONFIG_DATA_WIDTH         = DEFAULT_CONFIG_DATA_WIDTH,
  parameter int CONFIG_BEAT_COUNT         = DEFAULT_CONFIG_BEAT_COUNT,
  parameter int CONFIG_BEAT_COUNTER_WIDTH = $clog2(CONFIG_BEAT_COUNT) + 1
) (
  input  logic                                       clk,
  input  logic                                       i_aresetn,
  input  logic [CONFIG_DATA_WIDTH-1:0]               i_config_data,
  input  logic                                       i_config_valid,
  output logic                                       o_config_ready,
  output logic [CONFIG_DATA_WIDTH*CONFIG_BEAT_COUNT-1:0] o_config_pkt,
  output logic                                       o_config_pkt_valid,
  input  logic                                       i_config_serviced,
  output logic [CONFIG_BEAT_COUNTER_WIDTH-1:0]       o_config_beat_count
);

  localparam int PKT_W = CONFIG_DATA_WIDTH * CONFIG_BEAT_COUNT;
  localparam int CW    = CONFIG_BEAT_COUNTER_WIDTH;
`ifdef DLA_XBAR_CONFIG_PREFETCH_EN
  localparam int NUM_BUF = 2;
`else
  localparam int NUM_BUF = 1;
`endif

  xbar_cfg_state_e state_q;
  logic            ready_q;
  logic            pkt_valid_q;
  logic            front_sel;

  logic [NUM_BUF-1:0] buf_en;
  logic [NUM_BUF-1:0] buf_ready;
  logic [NUM_BUF-1:0] buf_done;
  logic [PKT_W-1:0]   buf_pkt   [NUM_BUF];
  logic [CW-1:0]      buf_count [NUM_BUF];

  for (genvar gi = 0; gi < NUM_BUF; gi++) begin : g_buf
    dla_xbar_config_collector_if #(.DW(CONFIG_DATA_WIDTH)) beat_if ();

    assign beat_if.config_data  = i_config_data;
    assign beat_if.config_valid = i_config_valid;
    assign buf_ready[gi]        = beat_if.config_ready;
    // The front buffer fills while collecting; the other (shadow) fills in HOLD.
    assign buf_en[gi] = ready_q & ((state_q == COLLECT) == (1'(gi) == front_sel));

    dla_xbar_config_beat_assembler #(
      .DW(CONFIG_DATA_WIDTH),
      .BC(CONFIG_BEAT_COUNT),
      .CW(CW)
    ) u_asm (
      .clk      (clk),
      .i_aresetn(i_aresetn),
      .en_i     (buf_en[gi]),
      .beat_if  (beat_if),
      .pkt_o    (buf_pkt[gi]),
      .count_o  (buf_count[gi]),
      .done_o   (buf_done[gi])
    );
  end

  assign o_config_ready     = |buf_ready;
  assign o_config_pkt_valid = pkt_valid_q;

`ifdef DLA_XBAR_CONFIG_PREFETCH_EN
  logic sel_q;
  logic shadow_full_q;

  assign front_sel           = sel_q;
  assign o_config_pkt        = buf_pkt[sel_q];
  assign o_config_beat_count = (state_q == HOLD) ? buf_count[~sel_q] : buf_count[sel_q];

  // Buffers swap roles on service, so a shadow packet is "transferred" by
  // reselecting it rather than copying, and a partial shadow keeps its beats.
  always_ff @(posedge clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q       <= COLLECT;
      ready_q       <= 1'b0;
      pkt_valid_q   <= 1'b0;
      sel_q         <= 1'b0;
      shadow_full_q <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          ready_q <= 1'b1;
          if (buf_done[sel_q]) begin
            state_q     <= HOLD;
            pkt_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (i_config_serviced) begin
            sel_q         <= ~sel_q;
            shadow_full_q <= 1'b0;
            ready_q       <= 1'b1;
            if (!(shadow_full_q || buf_done[~sel_q])) begin
              state_q     <= COLLECT;
              pkt_valid_q <= 1'b0;
            end
          end else if (buf_done[~sel_q]) begin
            // Both buffers full: stall the source until service.
            shadow_full_q <= 1'b1;
            ready_q       <= 1'b0;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end
`else
  assign front_sel           = 1'b0;
  assign o_config_pkt        = buf_pkt[0];
  assign o_config_beat_count = buf_count[0];

  always_ff @(posedge clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q     <= COLLECT;
      ready_q     <= 1'b0;
      pkt_valid_q <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          ready_q <= 1'b1;
          if (buf_done[0]) begin
            state_q     <= HOLD;
            ready_q     <= 1'b0;
            pkt_valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (i_config_serviced) begin
            state_q     <= COLLECT;
            ready_q     <= 1'b1;
            pkt_valid_q <= 1'b0;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_dla_xbar_config_collector.sv
// ---------------------------------------------------------------------------
// tb_dla_xbar_config_collector
// Directed self-checking bench for dla_xbar_config_collector (32-bit beats,
// 4 beats per packet). Build with DLA_XBAR_CONFIG_PREFETCH_EN defined to
// exercise the shadow-buffer variant.
// ---------------------------------------------------------------------------
module tb_dla_xbar_config_collector;

  localparam int DW = 32;
  localparam int BC = 4;
  localparam int CW = $clog2(BC) + 1;
  localparam int PW = DW * BC;
`ifdef DLA_XBAR_CONFIG_PREFETCH_EN
  localparam logic PF = 1'b1;
`else
  localparam logic PF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          serviced = 1'b0;
  logic [PW-1:0] pkt;
  logic          pkt_valid;
  logic [CW-1:0] beat_cnt;

  int n_checks = 0;
  int n_errors = 0;

  dla_xbar_config_collector_if #(.DW(DW)) cfg_if ();

  dla_xbar_config_collector #(
    .CONFIG_DATA_WIDTH(DW),
    .CONFIG_BEAT_COUNT(BC),
    .CONFIG_BEAT_COUNTER_WIDTH(CW)
  ) dut (
    .clk                (clk),
    .i_aresetn          (rst_n),
    .i_config_data      (cfg_if.config_data),
    .i_config_valid     (cfg_if.config_valid),
    .o_config_ready     (cfg_if.config_ready),
    .o_config_pkt       (pkt),
    .o_config_pkt_valid (pkt_valid),
    .i_config_serviced  (serviced),
    .o_config_beat_count(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Outputs are sampled 1 ns after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic service();
    serviced = 1'b1;
    tick();
    serviced = 1'b0;
    check_eq("svc_valid", pkt_valid, 0);
    check_eq("svc_ready", cfg_if.config_ready, 1);
    check_eq("svc_count", beat_cnt, 0);
    $display("txn service: pkt_valid=%0b ready=%0b", pkt_valid, cfg_if.config_ready);
  endtask

  logic [DW-1:0] b2b_words [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  logic [DW-1:0] gap_words [4] = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD};
  logic [DW-1:0] rst_words [4] = '{32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
  int            gap_cnt   [7] = '{1, 1, 2, 2, 3, 3, 0};

  initial begin
    cfg_if.config_valid = 1'b0;
    cfg_if.config_data  = '0;

    // Reset state
    repeat (2) tick();
    check_eq("rst_ready", cfg_if.config_ready, 0);
    check_eq("rst_valid", pkt_valid, 0);
    check_eq("rst_count", beat_cnt, 0);
    check_eq("rst_pkt", pkt, 0);
    rst_n = 1'b1;
    tick();
    check_eq("ready_after_rst", cfg_if.config_ready, 1);

    // Back-to-back packet
    for (int i = 0; i < 4; i++) begin
      cfg_if.config_valid = 1'b1;
      cfg_if.config_data  = b2b_words[i];
      tick();
      check_eq("b2b_count", beat_cnt, (i + 1) % 4);
      check_eq("b2b_valid", pkt_valid, (i == 3));
    end
    cfg_if.config_valid = 1'b0;
    check_eq("b2b_pkt", pkt, 128'h44444444_33333333_22222222_11111111);
    check_eq("b2b_hold_ready", cfg_if.config_ready, PF);
    $display("txn b2b packet: pkt=0x%0h valid=%0b", pkt, pkt_valid);

    // Long hold without service: packet stable, pending beat not consumed
`ifndef DLA_XBAR_CONFIG_PREFETCH_EN
    cfg_if.config_valid = 1'b1;
    cfg_if.config_data  = 32'hDEADBEEF;
`endif
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("hold_pkt", pkt, 128'h44444444_33333333_22222222_11111111);
      check_eq("hold_valid", pkt_valid, 1);
      check_eq("hold_ready", cfg_if.config_ready, PF);
      check_eq("hold_count", beat_cnt, 0);
    end
    cfg_if.config_valid = 1'b0;
    $display("txn hold 10 cycles: pkt=0x%0h", pkt);
    service();

    // Valid toggling 1,0,1,0...; service pulses in the gaps must be ignored
    for (int k = 0; k < 7; k++) begin
      if (k % 2 == 0) begin
        cfg_if.config_valid = 1'b1;
        cfg_if.config_data  = gap_words[k / 2];
        serviced            = 1'b0;
      end else begin
        cfg_if.config_valid = 1'b0;
        cfg_if.config_data  = 32'hBAD0BAD0;
        serviced            = 1'b1;
      end
      tick();
      check_eq("gap_count", beat_cnt, gap_cnt[k]);
      check_eq("gap_valid", pkt_valid, (k == 6));
    end
    cfg_if.config_valid = 1'b0;
    serviced            = 1'b0;
    check_eq("gap_pkt", pkt, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    $display("txn gapped packet: pkt=0x%0h valid=%0b", pkt, pkt_valid);
    service();

    // Reset mid-packet after two beats
    for (int i = 0; i < 2; i++) begin
      cfg_if.config_valid = 1'b1;
      cfg_if.config_data  = 32'h01010101 * (i + 1);
      tick();
    end
    cfg_if.config_valid = 1'b0;
    check_eq("pre_rst_count", beat_cnt, 2);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_count", beat_cnt, 0);
    check_eq("mid_rst_valid", pkt_valid, 0);
    check_eq("mid_rst_ready", cfg_if.config_ready, 0);
    check_eq("mid_rst_pkt", pkt, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check_eq("rel_ready_pre_edge", cfg_if.config_ready, 0);
    tick();
    check_eq("rel_ready", cfg_if.config_ready, 1);
    for (int i = 0; i < 4; i++) begin
      cfg_if.config_valid = 1'b1;
      cfg_if.config_data  = rst_words[i];
      tick();
      check_eq("post_rst_count", beat_cnt, (i + 1) % 4);
    end
    cfg_if.config_valid = 1'b0;
    check_eq("post_rst_valid", pkt_valid, 1);
    check_eq("post_rst_pkt", pkt, 128'h88888888_77777777_66666666_55555555);
    $display("txn packet after reset: pkt=0x%0h", pkt);
    service();

`ifdef DLA_XBAR_CONFIG_PREFETCH_EN
    // Eight streamed beats, service on the cycle the second packet completes
    for (int i = 1; i <= 8; i++) begin
      cfg_if.config_valid = 1'b1;
      cfg_if.config_data  = 32'h01010101 * i;
      serviced            = (i == 8);
      tick();
      check_eq("pf_count", beat_cnt, i % 4);
      check_eq("pf_ready", cfg_if.config_ready, 1);
      if (i >= 4) begin
        check_eq("pf_valid", pkt_valid, 1);
      end
      if (i >= 4 && i < 8) begin
        check_eq("pf_pkt1", pkt, 128'h04040404_03030303_02020202_01010101);
      end
    end
    cfg_if.config_valid = 1'b0;
    serviced            = 1'b0;
    check_eq("pf_pkt2", pkt, 128'h08080808_07070707_06060606_05050505);
    $display("txn prefetch second packet: pkt=0x%0h valid=%0b", pkt, pkt_valid);
    tick();
    check_eq("pf_pkt2_hold", pkt, 128'h08080808_07070707_06060606_05050505);
    check_eq("pf_valid_hold", pkt_valid, 1);
    service();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
